// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions for the fetch front end: NOP encoding, fetch FSM
// states and the fetch buffer entry layout {pc[XLEN], instr[32]}.
package riscv_pipe_pkg;

  localparam int          INSTR_W       = 32;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetchState_t;

  // Width of one buffered fetch entry: PC in the upper bits, instruction below.
  function automatic int entryWidth(input int xlen);
    return xlen + INSTR_W;
  endfunction

endpackage

// File: rtl/fetch_unit_buffered_fifo.sv
// fetch_fifo: synchronous FIFO with push/pop/full/empty/count and synchronous clear.
// DEPTH must be a power of 2 and at least 2.
module fetch_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wrData,
  output logic [WIDTH-1:0] rdData,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr, rdPtr;
  logic             doPush, doPop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // Push+pop together is always accepted, so count holds on a full or empty FIFO.
  assign doPush = push && (!full || pop);
  assign doPop  = pop && (!empty || push);

  assign rdData = mem[rdPtr];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
    end
  end

  // NOTE: storage is deliberately not reset; count and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (doPush && !clear) mem[wrPtr] <= wrData;
  end

endmodule

// File: rtl/fetch_unit_buffered.sv
// Buffered instruction fetch: PC, credit-limited requests to an in-order imem,
// redirect flush with stale-response dropping. Optional counters: FETCH_PERF_EN.
module fetch_unit_buffered
  import riscv_pipe_pkg::*;
#(
  parameter int               XLEN       = 64,
  parameter int               IMEM_AW    = 10,
  parameter int               FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0]  RESET_PC   = '0,
  parameter logic [31:0]      NOP_INSTR  = NOP_INSTR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [IMEM_AW-1:0] imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [31:0]        imem_rsp_data,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [31:0]        dec_instr,
  output logic [XLEN-1:0]    dec_pc,
  output logic [XLEN-1:0]    dec_pc_plus4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_redirects,
  output logic [31:0]        perf_bubbles
`endif
);

  localparam int              CW      = $clog2(FIFO_DEPTH) + 1;
  localparam int              EW      = entryWidth(XLEN);
  localparam logic [CW:0]     DEPTH_W = (CW+1)'(FIFO_DEPTH);

  fetchState_t       state, stateNext;
  logic [XLEN-1:0]   pc, pcNext;
  logic [CW-1:0]     outstanding, outNext;
  logic [CW-1:0]     dropCnt, dropNext;

  logic [CW-1:0]     fifoCount, sideCount;
  logic              fifoEmpty, fifoFull, sideEmpty, sideFull;
  logic [EW-1:0]     headEntry;
  logic [XLEN-1:0]   sideHeadPc;
  logic              accept, rspKeep, fifoPop;
  logic [CW:0]       creditSum;

  // Status pins the top never consults; kept to make the FIFO contract visible.
  logic unusedFifoStatus;
  assign unusedFifoStatus = &{1'b0, fifoFull, sideFull, sideEmpty, sideCount};

  assign creditSum      = {1'b0, fifoCount} + {1'b0, outstanding};
  assign imem_req_valid = !rst && !redirect_valid && (creditSum < DEPTH_W);
  assign imem_req_addr  = pc[IMEM_AW+1:2];
  assign accept         = imem_req_valid && imem_req_ready;

  // While draining (or in the redirect cycle itself) responses belong to the old path.
  assign rspKeep = imem_rsp_valid && (state == RUN) && !redirect_valid;

  assign dec_valid    = !fifoEmpty && !redirect_valid;
  assign fifoPop      = dec_valid && dec_ready;
  assign dec_instr    = fifoEmpty ? NOP_INSTR : headEntry[INSTR_W-1:0];
  assign dec_pc       = fifoEmpty ? '0 : headEntry[EW-1:INSTR_W];
  assign dec_pc_plus4 = dec_pc + XLEN'(4);

  fetch_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_instrFifo (
    .clk    (clk),
    .rst    (rst),
    .clear  (redirect_valid),
    .push   (rspKeep),
    .pop    (fifoPop),
    .wrData ({sideHeadPc, imem_rsp_data}),
    .rdData (headEntry),
    .full   (fifoFull),
    .empty  (fifoEmpty),
    .count  (fifoCount)
  );

  // Request PCs wait here so each kept response is paired with its own PC.
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_pcQueue (
    .clk    (clk),
    .rst    (rst),
    .clear  (redirect_valid),
    .push   (accept),
    .pop    (rspKeep),
    .wrData (pc),
    .rdData (sideHeadPc),
    .full   (sideFull),
    .empty  (sideEmpty),
    .count  (sideCount)
  );

  // NOTE: every signal gets a default first so no path through this block infers a latch.
  always_comb begin
    stateNext = state;
    pcNext    = pc;
    dropNext  = dropCnt;
    outNext   = outstanding + CW'(accept) - CW'(imem_rsp_valid);

    if (accept) pcNext = pc + XLEN'(4);

    if (redirect_valid) begin
      pcNext    = {redirect_pc[XLEN-1:2], 2'b00};
      dropNext  = outNext;
      stateNext = (outNext != '0) ? DRAIN : RUN;
    end else if ((state == DRAIN) && imem_rsp_valid) begin
      dropNext = dropCnt - CW'(1);
      if (dropNext == '0) stateNext = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      outstanding <= '0;
      dropCnt     <= '0;
    end else begin
      state       <= stateNext;
      pc          <= pcNext;
      outstanding <= outNext;
      dropCnt     <= dropNext;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched   <= '0;
      perf_redirects <= '0;
      perf_bubbles   <= '0;
    end else begin
      perf_fetched   <= perf_fetched + 32'(fifoPop);
      perf_redirects <= perf_redirects + 32'(redirect_valid);
      perf_bubbles   <= perf_bubbles + 32'(dec_ready && !dec_valid);
    end
  end
`endif

endmodule
